neuron: RTL and testbench

Single-layer perceptron neuron with two binary inputs, a constant bias input, and a step activation. Weights are compile-time parameters in signed-magnitude fixed-point (Q15.16 plus sign bit by default). The block computes the weighted sum each cycle and registers the thresholded result. It is the leaf compute element of the perceptron design; the default weights implement a 2-input OR.

---
 rtl/neuron_pkg.sv | 20 ++
 rtl/neuron_wsel.sv | 30 +++
 rtl/neuron.sv | 63 ++++++
 tb/tb_neuron.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// neuron_pkg: shared constants and helpers for the perceptron neuron.
//   DEF_SIGN / DEF_Q_M / DEF_Q_N : default weight format (sign, integer, fraction bits)
//   WIDTH                        : default weight width (sign + magnitude)
//   sm_to_tc()                   : signed-magnitude weight -> two's complement with
//                                  two guard bits, so a 3-term sum can never overflow
package neuron_pkg;

    localparam int DEF_SIGN = 1;
    localparam int DEF_Q_M  = 15;
    localparam int DEF_Q_N  = 16;
    localparam int WIDTH    = DEF_SIGN + DEF_Q_M + DEF_Q_N;

    // Both +0 and -0 map to 0 because negating a zero magnitude gives zero.
    function automatic logic signed [WIDTH+1:0] sm_to_tc(input logic [WIDTH-1:0] w);
        logic signed [WIDTH+1:0] mag;
        mag = $signed({3'b000, w[WIDTH-2:0]});
        return w[WIDTH-1] ? -mag : mag;
    endfunction

endpackage

// File: rtl/neuron_wsel.sv
// neuron_wsel: converts one signed-magnitude weight to two's complement and gates
// it by a binary input, standing in for a multiply by 0 or 1.
//   W      : weight width (sign bit + magnitude)
//   WEIGHT : compile-time weight, MSB = sign (1 = negative)
//   sel    : binary input; 1 passes the weight, 0 gives zero
//   prod   : gated weight, W+2 bit two's complement
module neuron_wsel
    import neuron_pkg::*;
#(
    parameter int             W      = WIDTH,
    parameter logic [W-1:0]   WEIGHT = '0
) (
    input  logic                sel,
    output logic signed [W+1:0] prod
);

    logic signed [W+1:0] weight_tc;

    // The package helper is fixed to the default width; other widths convert inline.
    if (W == WIDTH) begin : g_pkg_conv
        assign weight_tc = sm_to_tc(WEIGHT);
    end else begin : g_local_conv
        logic signed [W+1:0] mag;
        assign mag       = $signed({3'b000, WEIGHT[W-2:0]});
        assign weight_tc = WEIGHT[W-1] ? -mag : mag;
    end

    assign prod = sel ? weight_tc : '0;

endmodule

// File: rtl/neuron.sv
// neuron: two-input perceptron with a constant bias input and step activation.
// Default weights implement a 2-input OR.
//   clk_i : system clock, rising edge
//   rst_i : synchronous active-high reset, clears out
//   x1_in : binary input 1 (weight W1)
//   x2_in : binary input 2 (weight W2)
//   out   : registered activation, 1 when the weighted sum is strictly positive
module neuron
    import neuron_pkg::*;
#(
    parameter int SIGN = DEF_SIGN,   // must be 1
    parameter int Q_M  = DEF_Q_M,
    parameter int Q_N  = DEF_Q_N,
    parameter int BIAS = 1,
    parameter logic [SIGN+Q_M+Q_N-1:0] W1 = 32'b0_000000000000000_1100011101101111,
    parameter logic [SIGN+Q_M+Q_N-1:0] W2 = 32'b0_000000000000000_1011001000111111,
    parameter logic [SIGN+Q_M+Q_N-1:0] WB = 32'b1_000000000000000_0101001101100011
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic x1_in,
    input  logic x2_in,
    output logic out
);

    localparam int WL = SIGN + Q_M + Q_N;

    logic signed [WL+1:0] p1;
    logic signed [WL+1:0] p2;
    logic signed [WL+1:0] pb;
    logic signed [WL+1:0] sum;
    logic                 act;

    neuron_wsel #(.W(WL), .WEIGHT(W1)) u_wsel_x1 (
        .sel  (x1_in),
        .prod (p1)
    );

    neuron_wsel #(.W(WL), .WEIGHT(W2)) u_wsel_x2 (
        .sel  (x2_in),
        .prod (p2)
    );

    neuron_wsel #(.W(WL), .WEIGHT(WB)) u_wsel_bias (
        .sel  (1'(BIAS)),
        .prod (pb)
    );

    // Two guard bits cover the worst case of three full-scale terms.
    assign sum = p1 + p2 + pb;

    // Strictly positive: sign clear and not zero.
    assign act = !sum[WL+1] && (sum != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out <= 1'b0;
        end else begin
            out <= act;
        end
    end

endmodule

// File: tb/tb_neuron.sv
// tb_neuron: checks five neuron configurations driven by shared inputs.
//   bit 0 : default weights (OR)
//   bit 1 : W1=+0.5, WB=-0.5, BIAS=1            (sum exactly zero on (1,0))
//   bit 2 : W1=+0.5, WB=-(0.5-1 LSB), BIAS=1    (sum +1 LSB on (1,0))
//   bit 3 : BIAS=0, W1=-0, W2=+1 LSB
//   bit 4 : W1=W2=max positive, WB=max negative
module tb_neuron;

    logic       clk = 1'b0;
    logic       rst;
    logic       x1;
    logic       x2;
    logic [4:0] out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    neuron u_or (
        .clk_i(clk), .rst_i(rst), .x1_in(x1), .x2_in(x2), .out(out[0])
    );

    neuron #(.W1(32'h0000_8000), .WB(32'h8000_8000)) u_zero (
        .clk_i(clk), .rst_i(rst), .x1_in(x1), .x2_in(x2), .out(out[1])
    );

    neuron #(.W1(32'h0000_8000), .WB(32'h8000_7FFF)) u_lsb (
        .clk_i(clk), .rst_i(rst), .x1_in(x1), .x2_in(x2), .out(out[2])
    );

    neuron #(.BIAS(0), .W1(32'h8000_0000), .W2(32'h0000_0001)) u_nobias (
        .clk_i(clk), .rst_i(rst), .x1_in(x1), .x2_in(x2), .out(out[3])
    );

    neuron #(.W1(32'h7FFF_FFFF), .W2(32'h7FFF_FFFF), .WB(32'hFFFF_FFFF)) u_ext (
        .clk_i(clk), .rst_i(rst), .x1_in(x1), .x2_in(x2), .out(out[4])
    );

    typedef struct {
        logic       x1;
        logic       x2;
        logic [4:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[4];

    logic [4:0] sb_exp[$];
    string      sb_name[$];

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Compare whatever result the previous negedge scheduled, then drive the next one.
    task automatic apply(input logic a, input logic b, input logic [4:0] e, input string n);
        @(negedge clk);
        if (sb_exp.size() > 0) check(sb_name.pop_front(), out, sb_exp.pop_front());
        x1 = a;
        x2 = b;
        sb_exp.push_back(e);
        sb_name.push_back(n);
    endtask

    task automatic drain();
        @(negedge clk);
        while (sb_exp.size() > 0) check(sb_name.pop_front(), out, sb_exp.pop_front());
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 5'b00000, "in_00"};
        vecs[1] = '{1'b0, 1'b1, 5'b01111, "in_01"};
        vecs[2] = '{1'b1, 1'b0, 5'b00101, "in_10"};
        vecs[3] = '{1'b1, 1'b1, 5'b11111, "in_11"};

        rst = 1'b1;
        x1  = 1'b1;
        x2  = 1'b1;

        // Reset held two cycles with active inputs.
        @(negedge clk);
        @(negedge clk);
        check("reset_cyc1", out, 5'b00000);
        @(negedge clk);
        check("reset_cyc2", out, 5'b00000);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset", out, 5'b11111);

        // Truth table across all configurations.
        for (int i = 0; i < 4; i++) apply(vecs[i].x1, vecs[i].x2, vecs[i].exp, vecs[i].name);
        for (int i = 3; i >= 0; i--) apply(vecs[i].x1, vecs[i].x2, vecs[i].exp, vecs[i].name);

        // Random back-to-back inputs, one result per cycle.
        for (int i = 0; i < 24; i++) begin
            int k;
            k = int'($urandom_range(0, 3));
            apply(vecs[k].x1, vecs[k].x2, vecs[k].exp, "rand");
        end
        drain();

        // Latency: output holds until the next rising edge after an input change.
        apply(1'b1, 1'b0, 5'b00101, "lat_setup");
        @(negedge clk);
        check(sb_name.pop_front(), out, sb_exp.pop_front());
        x1 = 1'b0;
        x2 = 1'b0;
        #1;
        check_bit("lat_hold", out[0], 1'b1);
        @(posedge clk);
        #1;
        check_bit("lat_update", out[0], 1'b0);

        // Mid-stream reset discards the pending result.
        @(negedge clk);
        x1  = 1'b1;
        x2  = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_reset", out, 5'b00000);
        rst = 1'b0;
        @(negedge clk);
        check("mid_reset_release", out, 5'b11111);

        // A few more passes after reset recovery.
        for (int i = 0; i < 4; i++) apply(vecs[i].x1, vecs[i].x2, vecs[i].exp, vecs[i].name);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
